// File: rtl/usb_rx_line_decoder_if.sv
// Line-side and bit-timer-side signals of the USB RX line decoder.
// stuff_error exists only when USB_RX_STUFF_ERR_EN is defined.
interface usb_rx_line_decoder_if;
  logic d_plus_in;
  logic d_minus_in;
  logic shift_enable;
  logic d_edge;
  logic d_orig;
  logic bit_valid;
  logic invalid_bit;
  logic eop;
  logic rx_active;
`ifdef USB_RX_STUFF_ERR_EN
  logic stuff_error;
`endif

  modport master (
    output d_plus_in, d_minus_in, shift_enable,
`ifdef USB_RX_STUFF_ERR_EN
    input  stuff_error,
`endif
    input  d_edge, d_orig, bit_valid, invalid_bit, eop, rx_active
  );

  modport slave (
    input  d_plus_in, d_minus_in, shift_enable,
`ifdef USB_RX_STUFF_ERR_EN
    output stuff_error,
`endif
    output d_edge, d_orig, bit_valid, invalid_bit, eop, rx_active
  );
endinterface

// File: rtl/usb_rx_line_decoder.sv
// USB RX front end: D+/D- synchroniser, start-edge detect, NRZI decode, bit-stuff strip, SE0 EOP.
// Optional macro USB_RX_STUFF_ERR_EN adds stuff_error and aborts the packet on a stuff violation.
module usb_rx_line_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int STUFF_LEN   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  usb_rx_line_decoder_if.slave  bus
);
  localparam int CW = $clog2(STUFF_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_EOP1, S_EOP2} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sp_sync, r_sm_sync;
  logic                   r_sp_prev, r_d_edge, r_d_orig, r_bit_valid, r_invalid_bit;
  logic                   r_eop, r_rx_active, r_prev_line;
  logic [CW-1:0]          r_ones_cnt;

  logic                   w_sp, w_sm, w_se0, w_bit, w_decode;
  logic                   w_d_orig_nxt, w_bit_valid_nxt, w_invalid_nxt;
  logic                   w_eop_nxt, w_rx_active_nxt, w_prev_nxt;
  logic [CW-1:0]          w_ones_nxt;
`ifdef USB_RX_STUFF_ERR_EN
  logic                   r_stuff_error, w_stuff_error_nxt;
`endif

  assign w_sp  = r_sp_sync[SYNC_STAGES-1];
  assign w_sm  = r_sm_sync[SYNC_STAGES-1];
  assign w_se0 = ~w_sp & ~w_sm;
  assign w_bit = ~(w_sp ^ r_prev_line);

  // Chains reset to idle J so a quiet line produces no edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp_sync <= '1;
      r_sm_sync <= '0;
      r_sp_prev <= 1'b1;
      r_d_edge  <= 1'b0;
    end else begin
      r_sp_sync <= {r_sp_sync[SYNC_STAGES-2:0], bus.d_plus_in};
      r_sm_sync <= {r_sm_sync[SYNC_STAGES-2:0], bus.d_minus_in};
      r_sp_prev <= w_sp;
      r_d_edge  <= w_sp ^ r_sp_prev;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_d_orig      <= 1'b1;
      r_bit_valid   <= 1'b0;
      r_invalid_bit <= 1'b0;
      r_eop         <= 1'b0;
      r_rx_active   <= 1'b0;
      r_prev_line   <= 1'b1;
      r_ones_cnt    <= '0;
`ifdef USB_RX_STUFF_ERR_EN
      r_stuff_error <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_d_orig      <= w_d_orig_nxt;
      r_bit_valid   <= w_bit_valid_nxt;
      r_invalid_bit <= w_invalid_nxt;
      r_eop         <= w_eop_nxt;
      r_rx_active   <= w_rx_active_nxt;
      r_prev_line   <= w_prev_nxt;
      r_ones_cnt    <= w_ones_nxt;
`ifdef USB_RX_STUFF_ERR_EN
      r_stuff_error <= w_stuff_error_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_d_orig_nxt    = r_d_orig;
    w_bit_valid_nxt = 1'b0;
    w_invalid_nxt   = 1'b0;
    w_eop_nxt       = r_eop;
    w_rx_active_nxt = r_rx_active;
    w_prev_nxt      = r_prev_line;
    w_ones_nxt      = r_ones_cnt;
    w_decode        = 1'b0;
`ifdef USB_RX_STUFF_ERR_EN
    w_stuff_error_nxt = 1'b0;
`endif
    case (r_state)
      // shift_enable is ignored here, so an edge coinciding with a strobe takes no sample.
      S_IDLE: if (r_d_edge) begin
        w_state_nxt     = S_RECV;
        w_rx_active_nxt = 1'b1;
        w_ones_nxt      = '0;
        w_prev_nxt      = 1'b1;
      end
      S_RECV: if (bus.shift_enable) begin
        if (w_se0) begin
          w_state_nxt = S_EOP1;
          w_prev_nxt  = w_sp;
        end else begin
          w_decode = 1'b1;
        end
      end
      S_EOP1: if (bus.shift_enable) begin
        if (w_se0) begin
          w_state_nxt = S_EOP2;
          w_eop_nxt   = 1'b1;
          w_prev_nxt  = w_sp;
        end else begin
          w_state_nxt = S_RECV;
          w_decode    = 1'b1;
        end
      end
      S_EOP2: if (bus.shift_enable) begin
        w_state_nxt     = S_IDLE;
        w_eop_nxt       = 1'b0;
        w_rx_active_nxt = 1'b0;
        w_ones_nxt      = '0;
        w_prev_nxt      = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_decode) begin
      w_prev_nxt = w_sp;
      if (r_ones_cnt == CW'(STUFF_LEN)) begin
        w_invalid_nxt = 1'b1;
        w_ones_nxt    = '0;
`ifdef USB_RX_STUFF_ERR_EN
        // A 1 where a stuffed 0 belongs cannot be legal traffic: abort the packet.
        if (w_bit) begin
          w_stuff_error_nxt = 1'b1;
          w_state_nxt       = S_IDLE;
          w_rx_active_nxt   = 1'b0;
          w_prev_nxt        = 1'b1;
        end
`endif
      end else begin
        w_d_orig_nxt    = w_bit;
        w_bit_valid_nxt = 1'b1;
        w_ones_nxt      = w_bit ? CW'(r_ones_cnt + 1'b1) : '0;
      end
    end
  end

  assign bus.d_edge      = r_d_edge;
  assign bus.d_orig      = r_d_orig;
  assign bus.bit_valid   = r_bit_valid;
  assign bus.invalid_bit = r_invalid_bit;
  assign bus.eop         = r_eop;
  assign bus.rx_active   = r_rx_active;
`ifdef USB_RX_STUFF_ERR_EN
  assign bus.stuff_error = r_stuff_error;
`endif
endmodule

// File: tb/tb_usb_rx_line_decoder.sv
// Directed bench for usb_rx_line_decoder: edge detect, NRZI, stuffing, EOP, reset.
module tb_usb_rx_line_decoder;
  localparam int SYNC_STAGES = 2;
  localparam int STUFF_LEN   = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_rx_line_decoder_if bus();
  usb_rx_line_decoder #(.SYNC_STAGES(SYNC_STAGES), .STUFF_LEN(STUFF_LEN)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic s_bv, s_inv, s_orig, s_eop, s_act;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic line(input logic dp, input logic dm);
    bus.d_plus_in  = dp;
    bus.d_minus_in = dm;
  endtask

  // Settle the line, then strobe shift_enable for one cycle; capture outputs one cycle later.
  task automatic sample(input logic dp, input logic dm);
    line(dp, dm);
    repeat (7) tick();
    bus.shift_enable = 1'b1;
    tick();
    bus.shift_enable = 1'b0;
    s_bv   = bus.bit_valid;
    s_inv  = bus.invalid_bit;
    s_orig = bus.d_orig;
    s_eop  = bus.eop;
    s_act  = bus.rx_active;
  endtask

  function automatic logic [5:0] outs();
    return {bus.d_edge, bus.d_orig, bus.bit_valid, bus.invalid_bit, bus.eop, bus.rx_active};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    line(1'b1, 1'b0);
    bus.shift_enable = 1'b0;
    repeat (3) tick();
    checks++;
    if (outs() !== 6'b010000) begin
      errors++; $display("FAIL reset_outs got=%b exp=010000", outs());
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (outs() !== 6'b010000) begin
        errors++; $display("FAIL reset_release[%0d] got=%b exp=010000", i, outs());
      end
    end
  endtask

  task automatic test_edge();
    line(1'b0, 1'b1);
    for (int i = 1; i <= SYNC_STAGES + 2; i++) begin
      tick();
      checks++;
      if (bus.d_edge !== (i == SYNC_STAGES + 1)) begin
        errors++; $display("FAIL edge_cyc%0d got=%b exp=%b", i, bus.d_edge, (i == SYNC_STAGES + 1));
      end
      if (i == SYNC_STAGES + 1) begin
        checks++;
        if (bus.rx_active !== 1'b0) begin
          errors++; $display("FAIL edge_act_early got=%b exp=0", bus.rx_active);
        end
      end
    end
    checks++;
    if (bus.rx_active !== 1'b1) begin
      errors++; $display("FAIL edge_act got=%b exp=1", bus.rx_active);
    end
  endtask

  // KJKJKJKK after a J idle decodes to 0000_0001.
  task automatic test_sync();
    logic [0:7] pat_dp;
    logic [0:7] exp_orig;
    pat_dp   = 8'b0101_0100;
    exp_orig = 8'b0000_0001;
    for (int i = 0; i < 8; i++) begin
      sample(pat_dp[i], ~pat_dp[i]);
      checks++;
      if ({s_bv, s_inv, s_orig} !== {1'b1, 1'b0, exp_orig[i]}) begin
        errors++;
        $display("FAIL sync[%0d] bv/inv/orig got=%b%b%b exp=10%b", i, s_bv, s_inv, s_orig, exp_orig[i]);
      end
    end
    tick();
    checks++;
    if (bus.bit_valid !== 1'b0) begin
      errors++; $display("FAIL sync_bv_width got=%b exp=0", bus.bit_valid);
    end
  endtask

  task automatic test_stuff();
    int nvalid;
    sample(1'b1, 1'b0);
    checks++;
    if ({s_bv, s_orig} !== 2'b10) begin
      errors++; $display("FAIL stuff_pre got=%b%b exp=10", s_bv, s_orig);
    end
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      sample(1'b1, 1'b0);
      nvalid += int'(s_bv);
      checks++;
      if ({s_inv, s_orig} !== 2'b01) begin
        errors++; $display("FAIL stuff_one[%0d] inv/orig got=%b%b exp=01", i, s_inv, s_orig);
      end
    end
    sample(1'b0, 1'b1);
    nvalid += int'(s_bv);
    checks++;
    if ({s_bv, s_inv, s_orig} !== 3'b011) begin
      errors++; $display("FAIL stuff_bit bv/inv/orig got=%b%b%b exp=011", s_bv, s_inv, s_orig);
    end
    checks++;
    if (nvalid !== 6) begin
      errors++; $display("FAIL stuff_valid_count got=%0d exp=6", nvalid);
    end
    // Count restarted: a following 1 is data, not another stuff bit.
    sample(1'b0, 1'b1);
    checks++;
    if ({s_bv, s_inv, s_orig} !== 3'b101) begin
      errors++; $display("FAIL stuff_after got=%b%b%b exp=101", s_bv, s_inv, s_orig);
    end
    sample(1'b1, 1'b0);
    checks++;
    if ({s_bv, s_orig} !== 2'b10) begin
      errors++; $display("FAIL stuff_tail got=%b%b exp=10", s_bv, s_orig);
    end
  endtask

  task automatic test_eop();
    sample(1'b0, 1'b0);
    checks++;
    if ({s_bv, s_inv, s_eop, s_act} !== 4'b0001) begin
      errors++; $display("FAIL eop_se0a got=%b%b%b%b exp=0001", s_bv, s_inv, s_eop, s_act);
    end
    sample(1'b0, 1'b0);
    checks++;
    if ({s_bv, s_eop, s_act} !== 3'b011) begin
      errors++; $display("FAIL eop_se0b got=%b%b%b exp=011", s_bv, s_eop, s_act);
    end
    line(1'b1, 1'b0);
    repeat (3) tick();
    checks++;
    if (bus.eop !== 1'b1) begin
      errors++; $display("FAIL eop_hold got=%b exp=1", bus.eop);
    end
    sample(1'b1, 1'b0);
    checks++;
    if ({s_eop, s_act} !== 2'b00) begin
      errors++; $display("FAIL eop_end eop/act got=%b%b exp=00", s_eop, s_act);
    end
    repeat (10) tick();
    checks++;
    if (bus.rx_active !== 1'b0) begin
      errors++; $display("FAIL eop_idle act got=%b exp=0", bus.rx_active);
    end
  endtask

  task automatic test_glitch();
    line(1'b0, 1'b1);
    repeat (6) tick();
    checks++;
    if (bus.rx_active !== 1'b1) begin
      errors++; $display("FAIL glitch_start act got=%b exp=1", bus.rx_active);
    end
    sample(1'b0, 1'b1);
    checks++;
    if ({s_bv, s_orig} !== 2'b10) begin
      errors++; $display("FAIL glitch_k0 got=%b%b exp=10", s_bv, s_orig);
    end
    sample(1'b0, 1'b0);
    checks++;
    if ({s_bv, s_eop} !== 2'b00) begin
      errors++; $display("FAIL glitch_se0 bv/eop got=%b%b exp=00", s_bv, s_eop);
    end
    sample(1'b0, 1'b1);
    checks++;
    if ({s_bv, s_inv, s_eop, s_act} !== 4'b1001) begin
      errors++; $display("FAIL glitch_k bv/inv/eop/act got=%b%b%b%b exp=1001", s_bv, s_inv, s_eop, s_act);
    end
    sample(1'b0, 1'b0);
    sample(1'b0, 1'b0);
    sample(1'b1, 1'b0);
    checks++;
    if (s_act !== 1'b0) begin
      errors++; $display("FAIL glitch_close act got=%b exp=0", s_act);
    end
  endtask

  // Strobe held high across the start edge: no sample in IDLE, then two back-to-back samples.
  task automatic test_back_to_back();
    line(1'b0, 1'b1);
    bus.shift_enable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if ({bus.d_edge, bus.bit_valid} !== {(i == 3), 1'b0}) begin
        errors++; $display("FAIL b2b_idle[%0d] edge/bv got=%b%b exp=%b0", i, bus.d_edge, bus.bit_valid, (i == 3));
      end
    end
    tick();
    checks++;
    if ({bus.rx_active, bus.bit_valid} !== 2'b10) begin
      errors++; $display("FAIL b2b_enter act/bv got=%b%b exp=10", bus.rx_active, bus.bit_valid);
    end
    tick();
    checks++;
    if ({bus.bit_valid, bus.d_orig} !== 2'b10) begin
      errors++; $display("FAIL b2b_s1 bv/orig got=%b%b exp=10", bus.bit_valid, bus.d_orig);
    end
    tick();
    bus.shift_enable = 1'b0;
    checks++;
    if ({bus.bit_valid, bus.d_orig} !== 2'b11) begin
      errors++; $display("FAIL b2b_s2 bv/orig got=%b%b exp=11", bus.bit_valid, bus.d_orig);
    end
  endtask

  // Seven decoded 1s: the 7th lands on the stuff position with value 1.
  task automatic test_stuff_value();
    sample(1'b1, 1'b0);
    checks++;
    if ({s_bv, s_orig} !== 2'b10) begin
      errors++; $display("FAIL sv_pre got=%b%b exp=10", s_bv, s_orig);
    end
    for (int i = 0; i < 6; i++) sample(1'b1, 1'b0);
    checks++;
    if ({s_bv, s_orig} !== 2'b11) begin
      errors++; $display("FAIL sv_sixth got=%b%b exp=11", s_bv, s_orig);
    end
    sample(1'b1, 1'b0);
    checks++;
    if ({s_bv, s_inv} !== 2'b01) begin
      errors++; $display("FAIL sv_stuff bv/inv got=%b%b exp=01", s_bv, s_inv);
    end
`ifdef USB_RX_STUFF_ERR_EN
    checks++;
    if ({bus.stuff_error, s_act} !== 2'b10) begin
      errors++; $display("FAIL sv_err serr/act got=%b%b exp=10", bus.stuff_error, s_act);
    end
    tick();
    checks++;
    if ({bus.stuff_error, bus.rx_active} !== 2'b00) begin
      errors++; $display("FAIL sv_after serr/act got=%b%b exp=00", bus.stuff_error, bus.rx_active);
    end
`else
    checks++;
    if (s_act !== 1'b1) begin
      errors++; $display("FAIL sv_act got=%b exp=1", s_act);
    end
`endif
  endtask

  task automatic test_reset_mid();
    line(1'b0, 1'b1);
    repeat (6) tick();
    bus.shift_enable = 1'b1;
    tick();
    bus.shift_enable = 1'b0;
    checks++;
    if ({bus.bit_valid, bus.rx_active} !== 2'b11) begin
      errors++; $display("FAIL rmid_pre bv/act got=%b%b exp=11", bus.bit_valid, bus.rx_active);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (outs() !== 6'b010000) begin
      errors++; $display("FAIL rmid_async got=%b exp=010000", outs());
    end
`ifdef USB_RX_STUFF_ERR_EN
    checks++;
    if (bus.stuff_error !== 1'b0) begin
      errors++; $display("FAIL rmid_serr got=%b exp=0", bus.stuff_error);
    end
`endif
    line(1'b1, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (outs() !== 6'b010000) begin
        errors++; $display("FAIL rmid_release[%0d] got=%b exp=010000", i, outs());
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_edge();
    test_sync();
    test_stuff();
    test_eop();
    test_glitch();
    test_back_to_back();
    test_stuff_value();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/usb_rx_line_decoder.md
Name: usb_rx_line_decoder

Overview:
- Front-end stage of the USB RX path, directly upstream of the RX bit timer.
- Synchronises raw D+/D- and detects the first line edge that starts the timer.
- Samples the line on the timer's shift_enable strobe and NRZI-decodes each bit.
- Flags bit-stuff bits (invalid_bit, consumed by the timer) and detects SE0-based EOP.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per line (min 2).
- STUFF_LEN, 6, consecutive decoded 1s after which the next bit is a stuff bit.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- d_plus_in  in  1  raw D+ (asynchronous)
- d_minus_in  in  1  raw D- (asynchronous)
- shift_enable  in  1  one-cycle sample strobe from the RX bit timer
- d_edge  out  1  one-cycle pulse on any transition of synchronised D+
- d_orig  out  1  last NRZI-decoded bit
- bit_valid  out  1  one-cycle pulse: d_orig updated with a non-stuff data bit
- invalid_bit  out  1  one-cycle pulse: sampled bit was a stuff bit
- eop  out  1  level, end-of-packet detected
- rx_active  out  1  level, packet reception in progress

Behaviour:
- Reset: all sync flops on D+ = 1, all on D- = 0 (idle J). Outputs: d_edge=0, d_orig=1, bit_valid=0, invalid_bit=0, eop=0, rx_active=0. prev_line=1, ones_cnt=0, state=IDLE.
- Reset is asynchronous. Asserting rst mid-packet returns everything to reset values immediately; no pulse is emitted on release.
- Synchroniser: sp/sm = last stage of each SYNC_STAGES chain.
- d_edge: registered; 1 for exactly one cycle when sp differs from its value on the previous cycle. Latency from raw input change is SYNC_STAGES+1 cycles.
- SE0 = (sp==0 && sm==0).
- Sampling happens only on cycles with shift_enable=1 and state != IDLE. In IDLE, shift_enable is ignored.
- NRZI decode: bit = ~(sp ^ prev_line); prev_line <= sp on every sample.
- Stuff rule at each non-SE0 sample:
  - ones_cnt==STUFF_LEN: the bit is a stuff bit. Pulse invalid_bit the next cycle; d_orig unchanged; no bit_valid; ones_cnt <= 0.
  - Otherwise: d_orig <= bit and bit_valid pulses the next cycle. ones_cnt <= (bit ? ones_cnt+1 : 0).
  - ones_cnt width is clog2(STUFF_LEN+1) and it never wraps.
- All outputs are registered, so invalid_bit/bit_valid appear 1 cycle after the shift_enable cycle.
- FSM:
  - IDLE: on d_edge go to RECV; rx_active<=1; ones_cnt<=0; prev_line<=1.
  - RECV: a sample with SE0 goes to EOP1; no decode for that sample.
  - EOP1: a sample with SE0 goes to EOP2 and sets eop<=1. A sample without SE0 returns to RECV, treating that sample as a normal data bit (single-SE0 glitch tolerated).
  - EOP2: the next sample (J expected) goes to IDLE; eop<=0; rx_active<=0; ones_cnt<=0; prev_line<=1.
- Simultaneous d_edge and shift_enable in IDLE: the transition wins; no sample is taken that cycle.
- invalid_bit and bit_valid are never high in the same cycle.

Optional Feature:
- Macro USB_RX_STUFF_ERR_EN.
- Defined: adds output stuff_error (1 bit, reset 0). A stuff-position sample that decodes to 1 is a stuff violation. It pulses stuff_error for one cycle alongside invalid_bit, and the FSM goes to IDLE with rx_active<=0.
- Not defined: the port is absent, and every stuff-position sample is dropped as invalid_bit regardless of value.

Test Plan:
- Reset with lines idle (D+=1, D-=0), then toggle D+ to 0 -> d_edge=1 for 1 cycle, SYNC_STAGES+1 cycles after the change; rx_active=1 next cycle.
- SYNC pattern KJKJKJKK sampled via shift_enable every 8 cycles -> bit_valid pulses 8 times; d_orig sequence 0,0,0,0,0,0,0,1.
- Six decoded 1s (no line toggle for 6 samples) followed by a toggle -> invalid_bit=1 once after the 7th sample; bit_valid count stays 6; ones_cnt back to 0.
- SE0 on 2 consecutive samples then J -> eop=1 from the 2nd SE0 sample +1 cycle until after the J sample; then rx_active=0 and state IDLE.
- Single SE0 sample then K -> eop stays 0; the K sample produces bit_valid; rx_active remains 1.
- With USB_RX_STUFF_ERR_EN: 7 consecutive 1s -> stuff_error=1 and invalid_bit=1 in the same cycle, then rx_active=0. Separately, assert rst mid-packet -> all outputs at reset values in the same cycle.
